// File: rtl/mac_feeder.sv
// mac_feeder: holds two DIMxDIM operand matrices, streams A[i][k]/B[k][j]
// pairs into an external multiply-accumulate unit and hands each finished
// dot product C[i][j] to a consumer over a valid/ready result register.
module mac_feeder #(
  parameter  int Nbits = 8,
  parameter  int DIM   = 4,
  localparam int AW    = $clog2(DIM * DIM),
  localparam int CW    = $clog2(DIM)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ld_we,
  input  logic               ld_sel,
  input  logic [AW-1:0]      ld_addr,
  input  logic [Nbits-1:0]   ld_data,
  input  logic               start,
  output logic [Nbits-1:0]   mac_multiplier,
  output logic [Nbits-1:0]   mac_multiplicand,
  output logic               mac_clear,
  input  logic [2*Nbits-1:0] mac_acc,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [2*Nbits-1:0] res_data,
  output logic [CW-1:0]      res_row,
  output logic [CW-1:0]      res_col,
  output logic               busy,
  output logic               done
);

  typedef enum logic {
    IDLE = 1'b0,
    FEED = 1'b1
  } state_t;

  localparam logic [CW-1:0] K_LAST = CW'(DIM - 1);

  state_t               r_state;
  state_t               w_nextState;
  logic [Nbits-1:0]     r_memA [0:DIM*DIM-1];
  logic [Nbits-1:0]     r_memB [0:DIM*DIM-1];
  logic [CW-1:0]        r_i;
  logic [CW-1:0]        r_j;
  logic [CW-1:0]        r_k;
  logic                 r_cap;
  logic                 r_lastCap;
  logic [CW-1:0]        r_capRow;
  logic [CW-1:0]        r_capCol;
  logic                 r_done;
  logic                 r_resValid;
  logic [2*Nbits-1:0]   r_resData;
  logic [CW-1:0]        r_resRow;
  logic [CW-1:0]        r_resCol;

  logic [AW-1:0]        w_aIdx;
  logic [AW-1:0]        w_bIdx;
  logic [Nbits-1:0]     w_aData;
  logic [Nbits-1:0]     w_bData;
  logic                 w_slotFree;
  logic                 w_capture;
  logic                 w_advance;
  logic                 w_finish;
  logic [Nbits-1:0]     w_mult;
  logic [Nbits-1:0]     w_mcand;
  logic                 w_clear;

  // Operand addresses: A walks along row i, B walks down column j.
  always_comb begin
    w_aIdx  = AW'(r_i) * AW'(DIM) + AW'(r_k);
    w_bIdx  = AW'(r_k) * AW'(DIM) + AW'(r_j);
    w_aData = r_memA[w_aIdx];
    w_bData = r_memB[w_bIdx];
  end

  // Next state and mac drive; a capture blocked by a full result slot
  // zeroes the operands so the accumulator keeps the finished sum.
  always_comb begin
    w_nextState = r_state;
    w_slotFree  = !r_resValid || res_ready;
    w_capture   = 1'b0;
    w_advance   = 1'b0;
    w_finish    = 1'b0;
    w_mult      = '0;
    w_mcand     = '0;
    w_clear     = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_nextState = FEED;
        end
      end
      FEED: begin
        if (!(r_cap && !w_slotFree)) begin
          w_capture = r_cap;
          if (r_cap && r_lastCap) begin
            w_finish    = 1'b1;
            w_nextState = IDLE;
          end else begin
            w_advance = 1'b1;
            w_mult    = w_aData;
            w_mcand   = w_bData;
            w_clear   = (r_k == '0);
          end
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // State register, i/j/k counters and the pending-capture bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_i       <= '0;
      r_j       <= '0;
      r_k       <= '0;
      r_cap     <= 1'b0;
      r_lastCap <= 1'b0;
      r_capRow  <= '0;
      r_capCol  <= '0;
      r_done    <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_done  <= w_finish;
      if (w_capture) begin
        r_cap     <= 1'b0;
        r_lastCap <= 1'b0;
      end
      if (w_advance) begin
        if (r_k == K_LAST) begin
          r_k      <= '0;
          r_cap    <= 1'b1;
          r_capRow <= r_i;
          r_capCol <= r_j;
          if (r_j == K_LAST) begin
            r_j <= '0;
            if (r_i == K_LAST) begin
              r_i       <= '0;
              r_lastCap <= 1'b1;
            end else begin
              r_i <= r_i + 1'b1;
            end
          end else begin
            r_j <= r_j + 1'b1;
          end
        end else begin
          r_k <= r_k + 1'b1;
        end
      end
    end
  end

  // Operand storage; writes are only honoured while idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int n = 0; n < DIM * DIM; n++) begin
        r_memA[n] <= '0;
        r_memB[n] <= '0;
      end
    end else if (r_state == IDLE && ld_we) begin
      if (ld_sel) begin
        r_memB[ld_addr] <= ld_data;
      end else begin
        r_memA[ld_addr] <= ld_data;
      end
    end
  end

  // Result register: a capture reloads it, otherwise ready drains it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_resValid <= 1'b0;
      r_resData  <= '0;
      r_resRow   <= '0;
      r_resCol   <= '0;
    end else if (w_capture) begin
      r_resValid <= 1'b1;
      r_resData  <= mac_acc;
      r_resRow   <= r_capRow;
      r_resCol   <= r_capCol;
    end else if (res_ready) begin
      r_resValid <= 1'b0;
    end
  end

  assign mac_multiplier   = w_mult;
  assign mac_multiplicand = w_mcand;
  assign mac_clear        = w_clear;
  assign res_valid        = r_resValid;
  assign res_data         = r_resData;
  assign res_row          = r_resRow;
  assign res_col          = r_resCol;
  assign busy             = (r_state == FEED);
  assign done             = r_done;

endmodule

// File: tb/tb_mac_feeder.sv
// Bench for mac_feeder: behavioural mac model plus a matrix-product
// reference model, with randomized operands and consumer back-pressure.
module tb_mac_feeder;

  localparam int NB = 8;
  localparam int D  = 4;
  localparam int N  = D * D;
  localparam int AW = 4;
  localparam int CW = 2;

  logic            clk;
  logic            reset;
  logic            ld_we;
  logic            ld_sel;
  logic [AW-1:0]   ld_addr;
  logic [NB-1:0]   ld_data;
  logic            start;
  logic [NB-1:0]   mac_multiplier;
  logic [NB-1:0]   mac_multiplicand;
  logic            mac_clear;
  logic [2*NB-1:0] mac_acc;
  logic            res_valid;
  logic            res_ready;
  logic [2*NB-1:0] res_data;
  logic [CW-1:0]   res_row;
  logic [CW-1:0]   res_col;
  logic            busy;
  logic            done;

  int refA [N];
  int refB [N];
  int nCompared;
  int nMismatched;

  mac_feeder #(.Nbits(NB), .DIM(D)) dut (
    .clk              (clk),
    .reset            (reset),
    .ld_we            (ld_we),
    .ld_sel           (ld_sel),
    .ld_addr          (ld_addr),
    .ld_data          (ld_data),
    .start            (start),
    .mac_multiplier   (mac_multiplier),
    .mac_multiplicand (mac_multiplicand),
    .mac_clear        (mac_clear),
    .mac_acc          (mac_acc),
    .res_valid        (res_valid),
    .res_ready        (res_ready),
    .res_data         (res_data),
    .res_row          (res_row),
    .res_col          (res_col),
    .busy             (busy),
    .done             (done)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External mac: not tied to the feeder reset, so stale partial sums survive it.
  logic [2*NB-1:0] macAcc = '0;
  always @(posedge clk) begin
    if (mac_clear)
      macAcc <= (2*NB)'(mac_multiplier) * (2*NB)'(mac_multiplicand);
    else
      macAcc <= macAcc + (2*NB)'(mac_multiplier) * (2*NB)'(mac_multiplicand);
  end
  assign mac_acc = macAcc;

  task automatic loadAll();
    for (int n = 0; n < N; n++) begin
      @(negedge clk);
      ld_we = 1'b1; ld_sel = 1'b0; ld_addr = AW'(n); ld_data = NB'(refA[n]);
    end
    for (int n = 0; n < N; n++) begin
      @(negedge clk);
      ld_we = 1'b1; ld_sel = 1'b1; ld_addr = AW'(n); ld_data = NB'(refB[n]);
    end
    @(negedge clk);
    ld_we = 1'b0;
  endtask

  // readyMode: 0 always ready, 1 random ready, 2 ready low for 10 cycles from first valid.
  task automatic runMatrix(input string tag, input int readyMode, input int expDone,
                           input bit streamChk, input int pokeAt, input int startLoadVal);
    int expData [N];
    int resIdx, doneAt, doneCnt, s;
    if (startLoadVal >= 0) refA[0] = startLoadVal;
    for (int r = 0; r < D; r++)
      for (int c = 0; c < D; c++) begin
        s = 0;
        for (int k = 0; k < D; k++) s += refA[r*D+k] * refB[k*D+c];
        expData[r*D+c] = s % 65536;
      end
    @(negedge clk);
    start = 1'b1; res_ready = 1'b1;
    if (startLoadVal >= 0) begin
      ld_we = 1'b1; ld_sel = 1'b0; ld_addr = '0; ld_data = NB'(startLoadVal);
    end
    resIdx = 0; doneAt = -1; doneCnt = 0;
    for (int off = 1; off <= 400; off++) begin
      @(negedge clk);
      start = 1'b0; ld_we = 1'b0;
      if (off == pokeAt) begin
        start = 1'b1; ld_we = 1'b1; ld_sel = 1'b0; ld_addr = '0; ld_data = 8'd9;
      end
      case (readyMode)
        1:       res_ready = 1'($urandom_range(0, 1));
        2:       res_ready = !(off >= D + 2 && off < D + 12);
        default: res_ready = 1'b1;
      endcase
      if (off == D + 1 || off == D + 2) begin
        nCompared++;
        if (res_valid !== (off == D + 2)) begin
          nMismatched++;
          $display("[TB] FAIL %s first_valid_timing off=%0d got %b want %b", tag, off, res_valid, off == D + 2);
        end
      end
      if (streamChk && off <= D) begin
        nCompared++;
        if (mac_multiplier !== NB'(refA[off-1]) || mac_multiplicand !== NB'(refB[(off-1)*D])
            || mac_clear !== (off == 1)) begin
          nMismatched++;
          $display("[TB] FAIL %s stream k=%0d got %0d/%0d/%b want %0d/%0d/%b", tag, off - 1,
                   mac_multiplier, mac_multiplicand, mac_clear, refA[off-1], refB[(off-1)*D], off == 1);
        end
      end
      if (readyMode == 2 && off >= 2*D + 1 && off <= D + 11) begin
        nCompared++;
        if (mac_multiplier !== '0 || mac_multiplicand !== '0 || mac_clear !== 1'b0) begin
          nMismatched++;
          $display("[TB] FAIL %s stall_ops off=%0d got %0d/%0d/%b want 0/0/0", tag, off,
                   mac_multiplier, mac_multiplicand, mac_clear);
        end
      end
      if (expDone >= 0 && (off == expDone - 1 || off == expDone)) begin
        nCompared++;
        if (busy !== (off == expDone - 1)) begin
          nMismatched++;
          $display("[TB] FAIL %s busy off=%0d got %b want %b", tag, off, busy, off == expDone - 1);
        end
      end
      if (done === 1'b1) begin
        doneCnt++;
        if (doneAt < 0) doneAt = off;
      end
      if (res_valid && res_ready) begin
        nCompared++;
        if (resIdx >= N) begin
          nMismatched++;
          $display("[TB] FAIL %s extra_result got %0d want none", tag, res_data);
        end else if (res_data !== (2*NB)'(expData[resIdx]) || res_row !== CW'(resIdx / D)
                     || res_col !== CW'(resIdx % D)) begin
          nMismatched++;
          $display("[TB] FAIL %s result#%0d got %0d@(%0d,%0d) want %0d@(%0d,%0d)", tag, resIdx,
                   res_data, res_row, res_col, expData[resIdx], resIdx / D, resIdx % D);
        end
        resIdx++;
      end
      if (doneAt >= 0 && resIdx >= N && off >= doneAt + 2) break;
    end
    res_ready = 1'b1;
    nCompared++;
    if (resIdx != N || doneCnt != 1) begin
      nMismatched++;
      $display("[TB] FAIL %s counts got results=%0d dones=%0d want %0d/1", tag, resIdx, doneCnt, N);
    end
    if (expDone >= 0) begin
      nCompared++;
      if (doneAt != expDone) begin
        nMismatched++;
        $display("[TB] FAIL %s done_cycle got %0d want %0d", tag, doneAt, expDone);
      end
    end
  endtask

  task automatic test_reset();
    for (int pass = 0; pass < 2; pass++) begin
      nCompared++;
      if (mac_multiplier !== '0 || mac_multiplicand !== '0 || mac_clear !== 1'b0 ||
          res_valid !== 1'b0 || res_data !== '0 || res_row !== '0 || res_col !== '0 ||
          busy !== 1'b0 || done !== 1'b0) begin
        nMismatched++;
        $display("[TB] FAIL reset_state pass=%0d got m=%0d c=%0d clr=%b v=%b d=%0d r=%0d c=%0d busy=%b done=%b want all 0",
                 pass, mac_multiplier, mac_multiplicand, mac_clear, res_valid, res_data,
                 res_row, res_col, busy, done);
      end
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_identity();
    for (int r = 0; r < D; r++)
      for (int c = 0; c < D; c++) begin
        refA[r*D+c] = (r == c) ? 1 : 0;
        refB[r*D+c] = 4*r + c + 1;
      end
    loadAll();
    runMatrix("identity", 0, 66, 1'b1, 0, -1);
  endtask

  task automatic test_all_max();
    for (int n = 0; n < N; n++) begin refA[n] = 255; refB[n] = 255; end
    loadAll();
    runMatrix("all_max", 0, 66, 1'b1, 0, -1);
  endtask

  task automatic test_random();
    for (int t = 0; t < 3; t++) begin
      for (int n = 0; n < N; n++) begin
        refA[n] = int'($urandom_range(0, 255));
        refB[n] = int'($urandom_range(0, 255));
      end
      loadAll();
      runMatrix("random", (t == 0) ? 0 : 1, (t == 0) ? 66 : -1, 1'b1, 0, -1);
    end
  endtask

  // The first capture blocked by the 10-cycle ready-low window is element 1
  // at offset 2*D+1, so the run slips by (D+12)-(2*D+1) = 7 cycles.
  task automatic test_stall();
    for (int n = 0; n < N; n++) begin
      refA[n] = int'($urandom_range(0, 255));
      refB[n] = int'($urandom_range(0, 255));
    end
    loadAll();
    runMatrix("stall", 2, 66 + 7, 1'b0, 0, -1);
  endtask

  task automatic test_busy_ignore();
    for (int n = 0; n < N; n++) begin
      refA[n] = int'($urandom_range(10, 255));
      refB[n] = int'($urandom_range(0, 255));
    end
    loadAll();
    runMatrix("busy_poke", 0, 66, 1'b0, 20, -1);
    runMatrix("busy_rerun", 0, 66, 1'b1, 0, -1);
  endtask

  task automatic test_start_with_load();
    runMatrix("start_with_load", 0, 66, 1'b0, 0, int'($urandom_range(1, 255)));
  endtask

  task automatic test_reset_midrun();
    for (int n = 0; n < N; n++) begin
      refA[n] = int'($urandom_range(1, 255));
      refB[n] = int'($urandom_range(1, 255));
    end
    loadAll();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    nCompared++;
    if (mac_multiplier !== '0 || mac_multiplicand !== '0 || mac_clear !== 1'b0 ||
        res_valid !== 1'b0 || res_data !== '0 || res_row !== '0 || res_col !== '0 ||
        busy !== 1'b0 || done !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL reset_midrun got m=%0d c=%0d clr=%b v=%b d=%0d busy=%b want all 0",
               mac_multiplier, mac_multiplicand, mac_clear, res_valid, res_data, busy);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int n = 0; n < N; n++) begin refA[n] = 0; refB[n] = 0; end
    runMatrix("after_reset", 0, 66, 1'b1, 0, -1);
  endtask

  // Scenario sequence followed by the single summary line.
  initial begin
    nCompared = 0; nMismatched = 0;
    reset = 1'b1; ld_we = 1'b0; ld_sel = 1'b0; ld_addr = '0; ld_data = '0;
    start = 1'b0; res_ready = 1'b1;
    repeat (2) @(negedge clk);
    test_reset();
    test_identity();
    test_all_max();
    test_random();
    test_stall();
    test_busy_ignore();
    test_start_with_load();
    test_reset_midrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
